wb_port_arbiter: RTL

- Shares the single register-file write port among the five multi-cycle functional units: ALU, MEM, MUL, DIV and JUMP.
- Each FU hands its finished result over with a valid/ready handshake. The result goes into a one-entry per-FU holding buffer.
- The arbiter grants one buffered result per cycle and drives the registered write-back bus that the control unit and register file consume.
- It also exports a pending-destination mask, so the control unit can stall on RAW/WAW against results still waiting for the port.

---
 rtl/wb_port_arbiter_if.sv | 43 ++++
 rtl/wb_port_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle between the functional units, the arbiter and the
// register file / control unit. The arbiter connects through the slave modport.
interface wb_port_arbiter_if #(
    parameter int N_FU = 5,
    parameter int XLEN = 32
);
    logic [N_FU-1:0]      fu_valid;
    logic [5*N_FU-1:0]    fu_rd;
    logic [XLEN*N_FU-1:0] fu_data;
    logic [N_FU-1:0]      fu_ready;
    logic [N_FU-1:0]      flush_mask;
    logic                 wb_en;
    logic [4:0]           wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic [2:0]           wb_sel;
    logic [31:0]          pending_mask;

    modport master (
        output fu_valid,
        output fu_rd,
        output fu_data,
        output flush_mask,
        input  fu_ready,
        input  wb_en,
        input  wb_rd,
        input  wb_data,
        input  wb_sel,
        input  pending_mask
    );

    modport slave (
        input  fu_valid,
        input  fu_rd,
        input  fu_data,
        input  flush_mask,
        output fu_ready,
        output wb_en,
        output wb_rd,
        output wb_data,
        output wb_sel,
        output pending_mask
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: one holding buffer per FU, one registered write per cycle.
// Define WB_ROUND_ROBIN_EN for round-robin grants; otherwise the lowest FU index wins.
module wb_port_arbiter #(
    parameter int N_FU = 5,
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);

    localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]            buf_v_q;
    logic [N_FU-1:0]            buf_v_d;
    logic [N_FU-1:0][4:0]       buf_rd_q;
    logic [N_FU-1:0][4:0]       buf_rd_d;
    logic [N_FU-1:0][XLEN-1:0]  buf_data_q;
    logic [N_FU-1:0][XLEN-1:0]  buf_data_d;

    logic                       wb_en_q;
    logic                       wb_en_d;
    logic [4:0]                 wb_rd_q;
    logic [4:0]                 wb_rd_d;
    logic [XLEN-1:0]            wb_data_q;
    logic [XLEN-1:0]            wb_data_d;
    logic [2:0]                 wb_sel_q;
    logic [2:0]                 wb_sel_d;

    logic [N_FU-1:0]            eligible;
    logic [N_FU-1:0]            grant;
    logic [N_FU-1:0]            ready;
    logic [N_FU-1:0]            take;
    logic                       grant_any;
    logic [IDX_W-1:0]           grant_idx;
    logic [N_FU-1:0][31:0]      dest_onehot;
    logic [31:0]                pending;

    // A flushed entry is dropped this edge, so it must not compete for the port.
    assign eligible = buf_v_q & ~bus.flush_mask;

`ifdef WB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W:0]   cand;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_FU; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_FU)) begin
                cand = cand - (IDX_W+1)'(N_FU);
            end
            if (!grant_any && eligible[cand[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == IDX_W'(N_FU-1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = N_FU - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end
`endif

    assign grant = grant_any ? ({{(N_FU-1){1'b0}}, 1'b1} << grant_idx) : '0;

    // Ready does not look at fu_valid, which keeps the handshake loop-free.
    assign ready        = ~buf_v_q | grant;
    assign take         = bus.fu_valid & ready;
    assign bus.fu_ready = ready;

    generate
        for (genvar gi = 0; gi < N_FU; gi++) begin : g_buf
            assign buf_v_d[gi] = bus.flush_mask[gi] ? 1'b0 :
                                 take[gi]           ? (bus.fu_rd[5*gi +: 5] != 5'd0) :
                                                      (buf_v_q[gi] & ~grant[gi]);
            assign buf_rd_d[gi]   = take[gi] ? bus.fu_rd[5*gi +: 5]         : buf_rd_q[gi];
            assign buf_data_d[gi] = take[gi] ? bus.fu_data[XLEN*gi +: XLEN] : buf_data_q[gi];
            assign dest_onehot[gi] = buf_v_q[gi] ? (32'd1 << buf_rd_q[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        pending = '0;
        for (int k = 0; k < N_FU; k++) begin
            pending = pending | dest_onehot[k];
        end
    end

    assign bus.pending_mask = pending;

    // Destination and data hold through idle cycles; only enable and select drop.
    always_comb begin
        wb_en_d   = grant_any;
        wb_sel_d  = 3'd0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (grant_any) begin
            wb_sel_d  = 3'(grant_idx) + 3'd1;
            wb_rd_d   = buf_rd_q[grant_idx];
            wb_data_d = buf_data_q[grant_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_v_q    <= '0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_sel_q   <= '0;
        end else begin
            buf_v_q    <= buf_v_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_sel_q   <= wb_sel_d;
        end
    end

    assign bus.wb_en   = wb_en_q;
    assign bus.wb_rd   = wb_rd_q;
    assign bus.wb_data = wb_data_q;
    assign bus.wb_sel  = wb_sel_q;

endmodule
